// File: rtl/noc_pkg.sv
// ============================================================================
// Module : noc_pkg
// Desc   : Shared XY-NoC types: packet layout, default tag widths, decoder FSM
//          state encoding and a tag range helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package noc_pkg;

    localparam int C_DATA_WIDTH = 16;
    localparam int C_NUM_ROW    = 4;
    localparam int C_NUM_COL    = 4;
    localparam int C_ROW_W      = $clog2(C_NUM_ROW) + 1;
    localparam int C_COL_W      = $clog2(C_NUM_COL) + 1;

    typedef enum logic [1:0] {
        ST_UNCFG = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    typedef struct packed {
        logic [C_ROW_W-1:0]        row;
        logic [C_COL_W-1:0]        col;
        logic [2*C_DATA_WIDTH-1:0] data;
    } packet_t;

    // A tag names a real PE only when it lies inside the mesh dimension.
    function automatic logic tag_in_range(input int unsigned id, input int unsigned n);
        return id < n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dec_fifo.sv
// ============================================================================
// Module : dec_fifo
// Desc   : Synchronous FIFO with a registered head-of-queue output (show-ahead).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dec_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_rd_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_head_from_input;

    assign full      = (r_count == C_FULL);
    assign empty     = (r_count == '0);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    assign w_push   = push && !full;
    assign w_pop    = pop && r_out_valid;
    assign w_rd_nx  = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
    assign w_cnt_nx = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    // When the queue is (or becomes) empty, the word being pushed now is the new head.
    assign w_head_from_input = w_push && (r_count == CNT_W'(w_pop));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr    <= w_rd_nx;
            r_count     <= w_cnt_nx;
            r_out_valid <= (w_cnt_nx != '0);
            if (w_cnt_nx != '0) begin
                r_out_data <= w_head_from_input ? push_data : r_mem[w_rd_nx];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_dec.sv
// ============================================================================
// Module : data_dec
// Desc   : XY-NoC destination decoder: strips <row,col> tags from packets
//          addressed to this PE and buffers the payload for the PE.
// Config : DATA_DEC_BCAST_EN - all-ones row/col tag acts as a wildcard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_dec
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_ROW    = 4,
    parameter int NUM_COL    = 4,
    parameter int FIFO_DEPTH = 2,
    localparam int ROW_W     = $clog2(NUM_ROW) + 1,
    localparam int COL_W     = $clog2(NUM_COL) + 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cfg_we,
    input  logic [ROW_W-1:0]        cfg_row_id,
    input  logic [COL_W-1:0]        cfg_col_id,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ROW_W-1:0]        in_row,
    input  logic [COL_W-1:0]        in_col,
    input  logic [2*DATA_WIDTH-1:0] in_data,
    output logic                    pe_valid,
    input  logic                    pe_ready,
    output logic [2*DATA_WIDTH-1:0] pe_data,
    output logic [1:0]              state_o,
    output logic [15:0]             dlv_cnt
);

    state_e           r_state;
    logic [ROW_W-1:0] r_row_id;
    logic [COL_W-1:0] r_col_id;
    logic [15:0]      r_dlv_cnt;

    logic w_row_hit;
    logic w_col_hit;
    logic w_ids_valid;
    logic w_match;
    logic w_push;
    logic w_pop;
    logic w_fifo_full;
    logic w_fifo_empty;

`ifdef DATA_DEC_BCAST_EN
    assign w_row_hit = (in_row == r_row_id) || (in_row == '1);
    assign w_col_hit = (in_col == r_col_id) || (in_col == '1);
`else
    assign w_row_hit = (in_row == r_row_id);
    assign w_col_hit = (in_col == r_col_id);
`endif

    // Out-of-mesh local IDs are stored but can never be hit.
    assign w_ids_valid = tag_in_range(32'(r_row_id), NUM_ROW) &&
                         tag_in_range(32'(r_col_id), NUM_COL);
    assign w_match     = w_row_hit && w_col_hit && w_ids_valid;

    always_comb begin
        in_ready = 1'b1;
        case (r_state)
            ST_UNCFG: in_ready = 1'b1;
            ST_RUN:   in_ready = w_match ? !w_fifo_full : 1'b1;
            ST_FLUSH: in_ready = 1'b0;
            default:  in_ready = 1'b1;
        endcase
    end

    assign w_push  = in_valid && in_ready && (r_state == ST_RUN) && w_match;
    assign w_pop   = pe_valid && pe_ready;
    assign state_o = r_state;
    assign dlv_cnt = r_dlv_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= ST_UNCFG;
            r_row_id  <= '0;
            r_col_id  <= '0;
            r_dlv_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_dlv_cnt <= r_dlv_cnt + 16'd1;
            end
            case (r_state)
                ST_UNCFG: begin
                    if (cfg_we) begin
                        r_row_id  <= cfg_row_id;
                        r_col_id  <= cfg_col_id;
                        r_dlv_cnt <= '0;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (w_fifo_empty) begin
                        r_state <= ST_UNCFG;
                    end
                end
                default: r_state <= ST_UNCFG;
            endcase
        end
    end

    dec_fifo #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (w_push),
        .push_data (in_data),
        .pop       (w_pop),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .out_valid (pe_valid),
        .out_data  (pe_data)
    );

endmodule

`default_nettype wire
